alu_cmd_ctrl: RTL and testbench



---
 rtl/alu_sys_pkg.sv | 45 ++++
 rtl/alu_result_serializer.sv | 57 +++++
 rtl/alu_cmd_ctrl.sv | 170 +++++++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sys_pkg.sv
// Shared definitions for the ALU command path: frame command bytes,
// controller state encoding, timeout result and ALU function codes.
package alu_sys_pkg;

   // First byte of a frame selects the command.
   localparam logic [7:0]  CMD_ALU_FULL   = 8'hCC;  // CC, A, B, FUN
   localparam logic [7:0]  CMD_ALU_REUSE  = 8'hDD;  // DD, FUN (reuse stored A/B)

   // Result returned when the ALU never raises OUT_VALID.
   localparam logic [15:0] TIMEOUT_RESULT = 16'hFFFF;

   // Controller states, in frame order.
   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_GET_A    = 4'd1,
      ST_GET_B    = 4'd2,
      ST_GET_FUN  = 4'd3,
      ST_GATE     = 4'd4,
      ST_RUN      = 4'd5,
      ST_WAIT_RES = 4'd6,
      ST_SEND_LO  = 4'd7,
      ST_SEND_HI  = 4'd8
   } ctrl_state_e;

   // ALU function codes understood by ALU_Top.
   typedef enum logic [3:0] {
      FUN_ADD    = 4'b0000,
      FUN_SUB    = 4'b0001,
      FUN_MUL    = 4'b0010,
      FUN_DIV    = 4'b0011,
      FUN_AND    = 4'b0100,
      FUN_OR     = 4'b0101,
      FUN_NAND   = 4'b0110,
      FUN_NOR    = 4'b0111,
      FUN_XOR    = 4'b1000,
      FUN_XNOR   = 4'b1001,
      FUN_CMP_EQ = 4'b1010,
      FUN_CMP_GT = 4'b1011,
      FUN_CMP_LT = 4'b1100,
      FUN_SHR    = 4'b1101,
      FUN_SHL    = 4'b1110,
      FUN_NOP    = 4'b1111
   } alu_fun_e;

endpackage

// File: rtl/alu_result_serializer.sv
// Holds the captured ALU result and presents it to the UART TX path as
// two bytes, low byte first, with a valid/busy handshake.
module alu_result_serializer
   import alu_sys_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int OUT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic                  load,
   input  logic [OUT_WIDTH-1:0]  load_data,
   input  logic                  send_lo,
   input  logic                  send_hi,
   input  logic                  tx_busy,
   output logic [DATA_WIDTH-1:0] tx_p_data,
   output logic                  tx_d_vld,
   output logic                  tx_accept
);

   localparam int NUM_BYTES = OUT_WIDTH / DATA_WIDTH;

   logic [OUT_WIDTH-1:0]  result_reg;
   logic [DATA_WIDTH-1:0] result_byte [NUM_BYTES];

   // Result register: loaded once per operation, held while both bytes go out.
   always_ff @(posedge clk) begin
      if (srst) begin
         result_reg <= '0;
      end else if (load) begin
         result_reg <= load_data;
      end
   end

   // Split the result into byte lanes, lane 0 being the least significant.
   generate
      for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_byte_lane
         assign result_byte[gi] = result_reg[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // Data and valid follow the controller state, so they stay stable for as
   // long as the controller sits in a send state waiting for acceptance.
   always_comb begin
      tx_p_data = '0;
      if (send_hi) begin
         tx_p_data = result_byte[1];
      end else if (send_lo) begin
         tx_p_data = result_byte[0];
      end
   end

   assign tx_d_vld  = send_lo | send_hi;
   // A byte is taken at the edge where it is offered and TX is not busy.
   assign tx_accept = tx_d_vld & ~tx_busy;

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command controller in front of ALU_Top: parses RX frames, sequences the
// ALU clock gate and start pulse, captures the result (or a timeout marker)
// and returns it over UART TX as two bytes.
module alu_cmd_ctrl
   import alu_sys_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int OUT_WIDTH     = 16,
   parameter int ALU_FUN_WIDTH = 4,
   parameter int TIMEOUT       = 8
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
   input  logic                     RX_D_VLD,
   input  logic [OUT_WIDTH-1:0]     ALU_OUT,
   input  logic                     OUT_VALID,
   input  logic                     TX_BUSY,
   output logic [DATA_WIDTH-1:0]    A,
   output logic [DATA_WIDTH-1:0]    B,
   output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
   output logic                     ALU_EN,
   output logic                     CLK_GATE_EN,
   output logic [DATA_WIDTH-1:0]    TX_P_DATA,
   output logic                     TX_D_VLD,
   output logic                     RX_DROP
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   ctrl_state_e               state_reg, state_next;
   logic [CNT_W-1:0]          wait_cnt_reg;
   logic [DATA_WIDTH-1:0]     a_reg, b_reg;
   logic [ALU_FUN_WIDTH-1:0]  fun_reg;

   logic                      alu_en_next;
   logic                      gate_en_next;
   logic                      rx_drop_next;
   logic                      res_load;
   logic [OUT_WIDTH-1:0]      res_data;
   logic                      send_lo, send_hi;
   logic                      tx_accept;

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and control decode; the clock gate covers GATE, RUN and
   // WAIT_RES so the gated ALU clock is already running when ALU_EN arrives.
   always_comb begin
      state_next   = state_reg;
      alu_en_next  = 1'b0;
      gate_en_next = 1'b0;
      rx_drop_next = 1'b0;
      res_load     = 1'b0;
      res_data     = ALU_OUT;
      send_lo      = 1'b0;
      send_hi      = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (RX_D_VLD) begin
               if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_FULL)) begin
                  state_next = ST_GET_A;
               end else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_REUSE)) begin
                  state_next = ST_GET_FUN;
               end
            end
         end
         ST_GET_A: begin
            if (RX_D_VLD) state_next = ST_GET_B;
         end
         ST_GET_B: begin
            if (RX_D_VLD) state_next = ST_GET_FUN;
         end
         ST_GET_FUN: begin
            if (RX_D_VLD) state_next = ST_GATE;
         end
         ST_GATE: begin
            gate_en_next = 1'b1;
            rx_drop_next = RX_D_VLD;
            state_next   = ST_RUN;
         end
         ST_RUN: begin
            gate_en_next = 1'b1;
            alu_en_next  = 1'b1;
            rx_drop_next = RX_D_VLD;
            state_next   = ST_WAIT_RES;
         end
         ST_WAIT_RES: begin
            gate_en_next = 1'b1;
            rx_drop_next = RX_D_VLD;
            if (OUT_VALID) begin
               res_load   = 1'b1;
               state_next = ST_SEND_LO;
            end else if (wait_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
               res_load   = 1'b1;
               res_data   = OUT_WIDTH'(TIMEOUT_RESULT);
               state_next = ST_SEND_LO;
            end
         end
         ST_SEND_LO: begin
            send_lo      = 1'b1;
            rx_drop_next = RX_D_VLD;
            if (tx_accept) state_next = ST_SEND_HI;
         end
         ST_SEND_HI: begin
            send_hi      = 1'b1;
            rx_drop_next = RX_D_VLD;
            if (tx_accept) state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Result wait counter: runs only while waiting for OUT_VALID.
   always_ff @(posedge CLK) begin
      if (RST || state_reg != ST_WAIT_RES) begin
         wait_cnt_reg <= '0;
      end else begin
         wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end
   end

   // Operand capture: each field register loads only on its own frame byte.
   always_ff @(posedge CLK) begin
      if (RST) begin
         a_reg   <= '0;
         b_reg   <= '0;
         fun_reg <= '0;
      end else if (RX_D_VLD) begin
         case (state_reg)
            ST_GET_A:   a_reg   <= RX_P_DATA;
            ST_GET_B:   b_reg   <= RX_P_DATA;
            ST_GET_FUN: fun_reg <= RX_P_DATA[ALU_FUN_WIDTH-1:0];
            default: ;
         endcase
      end
   end

   alu_result_serializer #(
      .DATA_WIDTH (DATA_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH)
   ) u_serializer (
      .clk       (CLK),
      .srst      (RST),
      .load      (res_load),
      .load_data (res_data),
      .send_lo   (send_lo),
      .send_hi   (send_hi),
      .tx_busy   (TX_BUSY),
      .tx_p_data (TX_P_DATA),
      .tx_d_vld  (TX_D_VLD),
      .tx_accept (tx_accept)
   );

   assign A           = a_reg;
   assign B           = b_reg;
   assign ALU_FUN     = fun_reg;
   assign ALU_EN      = alu_en_next;
   assign CLK_GATE_EN = gate_en_next;
   assign RX_DROP     = rx_drop_next;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a small ALU model (OUT_VALID two
// cycles after ALU_EN) and a UART TX model (busy for 3 cycles per byte).
module tb_alu_cmd_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic [7:0]  RX_P_DATA;
   logic        RX_D_VLD;
   logic [15:0] ALU_OUT;
   logic        OUT_VALID;
   logic        TX_BUSY;
   logic [7:0]  A, B;
   logic [3:0]  ALU_FUN;
   logic        ALU_EN, CLK_GATE_EN;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VLD, RX_DROP;

   // bench-side models
   logic [15:0] model_res = 16'h0000;
   logic        model_en  = 1'b1;
   logic        tx_hold   = 1'b0;
   logic        pend      = 1'b0;
   logic        ov        = 1'b0;
   int          busy_cnt  = 0;

   // monitor state
   int          cyc = 0;
   int          en_cnt = 0, gate_cnt = 0, drop_cnt = 0;
   int          rx_last_cyc = 0, en_cyc = 0, ov_cyc = 0, txv_rise_cyc = 0;
   logic        txv_prev = 1'b0;
   logic [7:0]  cap_a = 0, cap_b = 0;
   logic [3:0]  cap_fun = 0;
   logic [7:0]  tx_q [$];

   int          n_cmp = 0;
   int          n_err = 0;

   assign ALU_OUT   = model_res;
   assign OUT_VALID = ov;
   assign TX_BUSY   = tx_hold || (busy_cnt != 0);

   alu_cmd_ctrl #(
      .DATA_WIDTH    (8),
      .OUT_WIDTH     (16),
      .ALU_FUN_WIDTH (4),
      .TIMEOUT       (8)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .RX_P_DATA   (RX_P_DATA),
      .RX_D_VLD    (RX_D_VLD),
      .ALU_OUT     (ALU_OUT),
      .OUT_VALID   (OUT_VALID),
      .TX_BUSY     (TX_BUSY),
      .A           (A),
      .B           (B),
      .ALU_FUN     (ALU_FUN),
      .ALU_EN      (ALU_EN),
      .CLK_GATE_EN (CLK_GATE_EN),
      .TX_P_DATA   (TX_P_DATA),
      .TX_D_VLD    (TX_D_VLD),
      .RX_DROP     (RX_DROP)
   );

   always #5 CLK = ~CLK;

   // ALU and TX models
   always @(posedge CLK) begin
      if (RST) begin
         pend <= 1'b0;
         ov   <= 1'b0;
      end else if (ALU_EN) begin
         pend <= 1'b1;
         ov   <= 1'b0;
      end else if (pend) begin
         pend <= 1'b0;
         ov   <= model_en;
      end else begin
         ov   <= 1'b0;
      end
      if (TX_D_VLD && !TX_BUSY) busy_cnt <= 3;
      else if (busy_cnt != 0)   busy_cnt <= busy_cnt - 1;
   end

   // Monitor: samples the cycle that ends at this edge
   always @(posedge CLK) begin
      if (RX_D_VLD)    rx_last_cyc = cyc;
      if (ALU_EN) begin
         en_cnt  = en_cnt + 1;
         en_cyc  = cyc;
         cap_a   = A;
         cap_b   = B;
         cap_fun = ALU_FUN;
      end
      if (OUT_VALID)   ov_cyc = cyc;
      if (CLK_GATE_EN) gate_cnt = gate_cnt + 1;
      if (RX_DROP)     drop_cnt = drop_cnt + 1;
      if (TX_D_VLD && !txv_prev) txv_rise_cyc = cyc;
      txv_prev = TX_D_VLD;
      if (TX_D_VLD && !TX_BUSY) tx_q.push_back(TX_P_DATA);
      cyc = cyc + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge CLK);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      @(negedge CLK);
      RX_D_VLD  = 1'b0;
   endtask

   task automatic wait_tx(input int n, input int budget);
      int k = 0;
      while (tx_q.size() < n && k < budget) begin
         @(negedge CLK);
         k++;
      end
      if (tx_q.size() < n) check_val("tx_wait_timeout", tx_q.size(), n);
      repeat (5) @(negedge CLK);
   endtask

   function automatic logic [31:0] tx_byte(input int idx);
      if (idx < tx_q.size()) return {24'h0, tx_q[idx]};
      return 32'hDEAD;
   endfunction

   task automatic check_quiet(input string tag);
      check_val({tag, "_A"},       A, 0);
      check_val({tag, "_B"},       B, 0);
      check_val({tag, "_FUN"},     ALU_FUN, 0);
      check_val({tag, "_ALU_EN"},  ALU_EN, 0);
      check_val({tag, "_GATE"},    CLK_GATE_EN, 0);
      check_val({tag, "_TX_DATA"}, TX_P_DATA, 0);
      check_val({tag, "_TX_VLD"},  TX_D_VLD, 0);
      check_val({tag, "_RX_DROP"}, RX_DROP, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int base, en0, g0, d0;
      RST = 1'b1; RX_D_VLD = 1'b0; RX_P_DATA = 8'h00;
      repeat (3) @(negedge CLK);
      check_quiet("reset");
      RST = 1'b0;
      repeat (2) @(negedge CLK);

      // 1: full frame, ADD 5+2 -> 0x0007
      model_res = 16'h0007; base = tx_q.size(); en0 = en_cnt; g0 = gate_cnt;
      send_byte(8'hCC); send_byte(8'h05); send_byte(8'h02); send_byte(8'h00);
      wait_tx(base + 2, 60);
      $display("txn1 full CC 05 02 00 -> tx %0h %0h", tx_byte(base), tx_byte(base + 1));
      check_val("t1_en_pulses", en_cnt - en0, 1);
      check_val("t1_A", cap_a, 8'h05);
      check_val("t1_B", cap_b, 8'h02);
      check_val("t1_FUN", cap_fun, 4'h0);
      check_val("t1_gate_cycles", gate_cnt - g0, 4);
      check_val("t1_lat_en", en_cyc - rx_last_cyc, 2);
      check_val("t1_lat_tx", txv_rise_cyc - ov_cyc, 1);
      check_val("t1_tx_lo", tx_byte(base), 8'h07);
      check_val("t1_tx_hi", tx_byte(base + 1), 8'h00);
      check_val("t1_gate_off", CLK_GATE_EN, 0);

      // 2: reuse frame, MUL with stored 5*2 -> 0x000A
      model_res = 16'h000A; base = tx_q.size(); en0 = en_cnt;
      send_byte(8'hDD); send_byte(8'h02);
      wait_tx(base + 2, 60);
      $display("txn2 reuse DD 02 -> tx %0h %0h", tx_byte(base), tx_byte(base + 1));
      check_val("t2_en_pulses", en_cnt - en0, 1);
      check_val("t2_A", cap_a, 8'h05);
      check_val("t2_B", cap_b, 8'h02);
      check_val("t2_FUN", cap_fun, 4'h2);
      check_val("t2_lat_en", en_cyc - rx_last_cyc, 2);
      check_val("t2_tx_lo", tx_byte(base), 8'h0A);
      check_val("t2_tx_hi", tx_byte(base + 1), 8'h00);

      // 3: junk first byte, then DIV 4/2 -> 0x0002
      model_res = 16'h0002; base = tx_q.size(); en0 = en_cnt; d0 = drop_cnt;
      send_byte(8'h55);
      repeat (3) @(negedge CLK);
      check_val("t3_junk_no_en", en_cnt - en0, 0);
      send_byte(8'hCC); send_byte(8'h04); send_byte(8'h02); send_byte(8'h03);
      wait_tx(base + 2, 60);
      $display("txn3 55 then CC 04 02 03 -> tx %0h %0h", tx_byte(base), tx_byte(base + 1));
      check_val("t3_no_drop", drop_cnt - d0, 0);
      check_val("t3_en_pulses", en_cnt - en0, 1);
      check_val("t3_A", cap_a, 8'h04);
      check_val("t3_B", cap_b, 8'h02);
      check_val("t3_FUN", cap_fun, 4'h3);
      check_val("t3_tx_lo", tx_byte(base), 8'h02);
      check_val("t3_tx_hi", tx_byte(base + 1), 8'h00);

      // 4: OUT_VALID withheld -> timeout result 0xFFFF
      model_en = 1'b0; model_res = 16'h1234; base = tx_q.size(); en0 = en_cnt; g0 = gate_cnt;
      send_byte(8'hCC); send_byte(8'h05); send_byte(8'h02); send_byte(8'h01);
      wait_tx(base + 2, 80);
      $display("txn4 timeout CC 05 02 01 -> tx %0h %0h", tx_byte(base), tx_byte(base + 1));
      check_val("t4_en_pulses", en_cnt - en0, 1);
      check_val("t4_FUN", cap_fun, 4'h1);
      check_val("t4_gate_cycles", gate_cnt - g0, 10);
      check_val("t4_tx_lo", tx_byte(base), 8'hFF);
      check_val("t4_tx_hi", tx_byte(base + 1), 8'hFF);
      check_val("t4_gate_off", CLK_GATE_EN, 0);
      model_en = 1'b1;

      // 5: TX busy held during SEND_LO, RX byte injected -> dropped once
      model_res = 16'h03A8; base = tx_q.size(); d0 = drop_cnt;
      tx_hold = 1'b1;
      send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte(8'h02);
      begin
         int k = 0;
         while (!TX_D_VLD && k < 40) begin
            @(negedge CLK);
            k++;
         end
         check_val("t5_tx_offered", TX_D_VLD, 1);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         check_val("t5_hold_vld", TX_D_VLD, 1);
         check_val("t5_hold_data", TX_P_DATA, 8'hA8);
         RX_P_DATA = 8'h77;
         RX_D_VLD  = (i == 5);
      end
      RX_D_VLD = 1'b0;
      check_val("t5_none_sent", tx_q.size() - base, 0);
      tx_hold = 1'b0;
      wait_tx(base + 2, 60);
      $display("txn5 busy-hold CC 12 34 02 -> tx %0h %0h", tx_byte(base), tx_byte(base + 1));
      check_val("t5_drop_once", drop_cnt - d0, 1);
      check_val("t5_tx_lo", tx_byte(base), 8'hA8);
      check_val("t5_tx_hi", tx_byte(base + 1), 8'h03);

      // 6: reset while in GET_B, then a fresh frame
      base = tx_q.size(); en0 = en_cnt;
      send_byte(8'hCC); send_byte(8'h05);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      check_quiet("t6_after_rst");
      RST = 1'b0;
      repeat (10) @(negedge CLK);
      check_val("t6_no_tx", tx_q.size() - base, 0);
      check_val("t6_no_en", en_cnt - en0, 0);
      model_res = 16'h0001;
      send_byte(8'hCC); send_byte(8'h05); send_byte(8'h05); send_byte(8'h09);
      wait_tx(base + 2, 60);
      $display("txn6 post-reset CC 05 05 09 -> tx %0h %0h", tx_byte(base), tx_byte(base + 1));
      check_val("t6_A", cap_a, 8'h05);
      check_val("t6_B", cap_b, 8'h05);
      check_val("t6_FUN", cap_fun, 4'h9);
      check_val("t6_tx_lo", tx_byte(base), 8'h01);
      check_val("t6_tx_hi", tx_byte(base + 1), 8'h00);
      check_val("t6_tx_total", tx_q.size() - base, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
